// File: rtl/pe_result_pkg.sv
// pe_result_pkg: shared scan-order constants, FSM encoding and scan-to-flat index mapping.
package pe_result_pkg;

    localparam logic SCAN_COL = 1'b0;
    localparam logic SCAN_ROW = 1'b1;

    typedef enum logic {IDLE, RUN} state_t;

    // result_flat stores element (r,c) at index c*rows + r, so column-major scan is the identity.
    function automatic int unsigned flat_idx(input logic mode, input int unsigned pos,
                                             input int unsigned rows, input int unsigned cols);
        return (mode == SCAN_ROW) ? (pos % cols) * rows + pos / cols : pos;
    endfunction

endpackage

// File: rtl/pe_result_bank.sv
// pe_result_bank: one snapshot register with whole-vector write and K combinational element read ports.
module pe_result_bank #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int DW   = 16,
    parameter int K    = 2,
    parameter int IW   = 6
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ROWS*COLS*DW-1:0]  wr_data,
    input  logic [K*IW-1:0]          rd_idx,
    output logic [K*DW-1:0]          rd_data
);

    logic [DW-1:0] mem [ROWS*COLS];

    always_ff @(posedge clk)
        if (we)
            for (int i = 0; i < ROWS*COLS; i++)
                mem[i] <= wr_data[i*DW +: DW];

    for (genvar k = 0; k < K; k++) begin : g_rd
        assign rd_data[k*DW +: DW] = mem[rd_idx[k*IW +: IW]];
    end

endmodule

// File: rtl/pe_result_stream_cache.sv
// pe_result_stream_cache: ping-pong snapshot store of PE results, drained as OW-bit ready/valid beats
// in column- or row-major order.
module pe_result_stream_cache
    import pe_result_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int DW   = 16,
    parameter int OW   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     save_sop,
    input  logic [ROWS*COLS*DW-1:0]  result_flat,
    input  logic                     rd_mode,
    input  logic                     top_rd_sop,
    input  logic                     top_rd_ready,
    output logic                     top_rd_vld,
    output logic [OW-1:0]            top_rd_data,
    output logic                     top_rd_eop,
    output logic                     top_rd_err,
    output logic                     save_ovf,
    output logic [1:0]               fill_cnt
);

    localparam int K     = OW / DW;
    localparam int NE    = ROWS * COLS;
    localparam int NBEAT = NE * DW / OW;
    localparam int BW    = NBEAT > 1 ? $clog2(NBEAT) : 1;
    localparam int IW    = NE > 1 ? $clog2(NE) : 1;

    state_t          state, state_nx;
    logic [1:0]      full, full_nx;
    logic            wr_ptr, wr_ptr_nx, rd_ptr, rd_ptr_nx;
    logic            mode, mode_nx, err_nx, ovf_nx;
    logic [BW-1:0]   beat_idx, beat_nx;
    logic            save_ok, start, hs, last, drain;
    logic [K*IW-1:0] rd_idx;
    logic [OW-1:0]   bank_data [2];

    for (genvar k = 0; k < K; k++) begin : g_idx
        assign rd_idx[k*IW +: IW] = IW'(flat_idx(mode, 32'(beat_idx) * K + k, ROWS, COLS));
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        pe_result_bank #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .K(K), .IW(IW)) u_bank (
            .clk     (clk),
            .we      (save_ok && (wr_ptr == 1'(b))),
            .wr_data (result_flat),
            .rd_idx  (rd_idx),
            .rd_data (bank_data[b])
        );
    end

    assign top_rd_vld  = state == RUN;
    assign top_rd_eop  = top_rd_vld && last;
    assign top_rd_data = top_rd_vld ? bank_data[rd_ptr] : '0;
    assign fill_cnt    = 2'(full[0]) + 2'(full[1]);

    // All decisions use the registered (pre-edge) bank status.
    always_comb begin
        save_ok   = save_sop && !full[wr_ptr];
        start     = state == IDLE && top_rd_sop && full[rd_ptr];
        hs        = state == RUN && top_rd_ready;
        last      = beat_idx == BW'(NBEAT - 1);
        drain     = hs && last;
        full_nx   = (full | (save_ok ? (wr_ptr ? 2'b10 : 2'b01) : 2'b00))
                  & ~(drain ? (rd_ptr ? 2'b10 : 2'b01) : 2'b00);
        wr_ptr_nx = wr_ptr ^ save_ok;
        rd_ptr_nx = rd_ptr ^ drain;
        state_nx  = start ? RUN : drain ? IDLE : state;
        mode_nx   = start ? rd_mode : mode;
        beat_nx   = (start || drain) ? '0 : hs ? beat_idx + 1'b1 : beat_idx;
        err_nx    = top_rd_sop && !start;
        ovf_nx    = save_sop && !save_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            full       <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            mode       <= SCAN_COL;
            beat_idx   <= '0;
            top_rd_err <= 1'b0;
            save_ovf   <= 1'b0;
        end else begin
            state      <= state_nx;
            full       <= full_nx;
            wr_ptr     <= wr_ptr_nx;
            rd_ptr     <= rd_ptr_nx;
            mode       <= mode_nx;
            beat_idx   <= beat_nx;
            top_rd_err <= err_nx;
            save_ovf   <= ovf_nx;
        end
    end

endmodule

// File: tb/tb_pe_result_stream_cache.sv
// tb_pe_result_stream_cache: directed scenarios with a scoreboard queue checked by a beat monitor.
module tb_pe_result_stream_cache;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          save_sop = 1'b0;
    logic [1023:0] result_flat = '0;
    logic          rd_mode = 1'b0;
    logic          top_rd_sop = 1'b0;
    logic          top_rd_ready = 1'b0;
    logic          top_rd_vld;
    logic [31:0]   top_rd_data;
    logic          top_rd_eop;
    logic          top_rd_err;
    logic          save_ovf;
    logic [1:0]    fill_cnt;

    int errors = 0;
    int checks = 0;
    logic [32:0] sb [$];
    logic [31:0] got [64];
    int nhs = 0;
    logic stall_v = 1'b0;
    logic [32:0] stall_q;
    logic [3:0] pat = 4'b1001;

    pe_result_stream_cache dut (
        .clk          (clk),
        .rst          (rst),
        .save_sop     (save_sop),
        .result_flat  (result_flat),
        .rd_mode      (rd_mode),
        .top_rd_sop   (top_rd_sop),
        .top_rd_ready (top_rd_ready),
        .top_rd_vld   (top_rd_vld),
        .top_rd_data  (top_rd_data),
        .top_rd_eop   (top_rd_eop),
        .top_rd_err   (top_rd_err),
        .save_ovf     (save_ovf),
        .fill_cnt     (fill_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1023:0] make_flat(input logic [7:0] tag);
        logic [1023:0] f = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                f[(c*8+r)*16 +: 16] = {tag, 4'(r), 4'(c)};
        return f;
    endfunction

    function automatic logic [31:0] exp_beat(input logic [7:0] tag, input bit mode, input int b);
        logic [31:0] v;
        int p, r, c;
        v = '0;
        for (int k = 0; k < 2; k++) begin
            p = b * 2 + k;
            r = mode ? p / 8 : p % 8;
            c = mode ? p % 8 : p / 8;
            v[k*16 +: 16] = {tag, 4'(r), 4'(c)};
        end
        return v;
    endfunction

    // Monitor: every accepted beat must match the head of the scoreboard; stalled beats must hold.
    always @(negedge clk) begin
        if (!rst && stall_v)
            chk("stall_hold", {31'b0, top_rd_vld, top_rd_eop, top_rd_data}, {31'b0, 1'b1, stall_q});
        if (!rst && top_rd_vld && top_rd_ready) begin
            if (sb.size() == 0)
                chk("unexpected_beat", {32'b0, top_rd_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            else
                chk("beat", {31'b0, top_rd_eop, top_rd_data}, {31'b0, sb.pop_front()});
            if (nhs < 64) got[nhs] = top_rd_data;
            nhs++;
        end
        stall_v = !rst && top_rd_vld && !top_rd_ready;
        stall_q = {top_rd_eop, top_rd_data};
    end

    task automatic save(input logic [7:0] tag);
        result_flat = make_flat(tag);
        save_sop = 1'b1;
        tick;
        save_sop = 1'b0;
    endtask

    task automatic read(input logic [7:0] tag, input bit mode);
        for (int b = 0; b < 32; b++)
            sb.push_back({b == 31, exp_beat(tag, mode, b)});
        nhs = 0;
        rd_mode = mode;
        top_rd_ready = 1'b1;
        top_rd_sop = 1'b1;
        tick;
        top_rd_sop = 1'b0;
        chk("first_vld", {63'b0, top_rd_vld}, 64'd1);
    endtask

    task automatic run_stream(input bit bp, input int sop_at, input int rst_at);
        int i;
        i = 0;
        while (sb.size() != 0 && i < 500) begin
            top_rd_ready = bp ? pat[i % 4] : 1'b1;
            top_rd_sop = (i == sop_at);
            rd_mode = ~rd_mode;
            rst = (i == rst_at);
            tick;
            top_rd_sop = 1'b0;
            if (i == sop_at) chk("err_in_run", {63'b0, top_rd_err}, 64'd1);
            if (i == rst_at) begin
                chk("rst_vld", {63'b0, top_rd_vld}, 64'd0);
                chk("rst_fill", {62'b0, fill_cnt}, 64'd0);
                rst = 1'b0;
                sb.delete();
            end
            i++;
        end
        chk("stream_done", {32'b0, sb.size()}, 64'd0);
        sb.delete();
        chk("vld_drop", {63'b0, top_rd_vld}, 64'd0);
    endtask

    initial begin
        tick;
        tick;
        rst = 1'b0;
        chk("rst_vld0", {63'b0, top_rd_vld}, 64'd0);
        chk("rst_data0", {32'b0, top_rd_data}, 64'd0);
        chk("rst_eop0", {63'b0, top_rd_eop}, 64'd0);
        chk("rst_err0", {63'b0, top_rd_err}, 64'd0);
        chk("rst_ovf0", {63'b0, save_ovf}, 64'd0);
        chk("rst_fill0", {62'b0, fill_cnt}, 64'd0);

        // column-major drain
        save(8'h00);
        chk("fill_after_save", {62'b0, fill_cnt}, 64'd1);
        read(8'h00, 1'b0);
        chk("fill_during_run", {62'b0, fill_cnt}, 64'd1);
        run_stream(1'b0, -1, -1);
        chk("hs_col", {32'b0, nhs}, 64'd32);
        chk("col_beat0", {32'b0, got[0]}, 64'h0010_0000);
        chk("col_beat1", {32'b0, got[1]}, 64'h0030_0020);
        chk("col_beat31", {32'b0, got[31]}, 64'h0077_0067);
        chk("fill_after_drain", {62'b0, fill_cnt}, 64'd0);

        // row-major drain
        save(8'h00);
        read(8'h00, 1'b1);
        run_stream(1'b0, -1, -1);
        chk("row_beat0", {32'b0, got[0]}, 64'h0001_0000);
        chk("row_beat4", {32'b0, got[4]}, 64'h0011_0010);
        chk("row_beat31", {32'b0, got[31]}, 64'h0077_0076);

        // backpressure
        save(8'h05);
        read(8'h05, 1'b0);
        run_stream(1'b1, -1, -1);
        chk("hs_bp", {32'b0, nhs}, 64'd32);

        // ping-pong and overflow
        save(8'h0A);
        save(8'h0B);
        chk("fill_two", {62'b0, fill_cnt}, 64'd2);
        chk("no_ovf", {63'b0, save_ovf}, 64'd0);
        save(8'h0C);
        chk("ovf_pulse", {63'b0, save_ovf}, 64'd1);
        chk("fill_ovf", {62'b0, fill_cnt}, 64'd2);
        tick;
        chk("ovf_clear", {63'b0, save_ovf}, 64'd0);
        read(8'h0A, 1'b0);
        run_stream(1'b0, -1, -1);
        chk("fill_after_a", {62'b0, fill_cnt}, 64'd1);
        read(8'h0B, 1'b0);
        run_stream(1'b0, -1, -1);
        chk("fill_after_b", {62'b0, fill_cnt}, 64'd0);

        // read errors
        top_rd_sop = 1'b1;
        tick;
        top_rd_sop = 1'b0;
        chk("err_empty", {63'b0, top_rd_err}, 64'd1);
        chk("err_empty_vld", {63'b0, top_rd_vld}, 64'd0);
        tick;
        chk("err_clear", {63'b0, top_rd_err}, 64'd0);
        result_flat = make_flat(8'h0D);
        save_sop = 1'b1;
        top_rd_sop = 1'b1;
        tick;
        save_sop = 1'b0;
        top_rd_sop = 1'b0;
        chk("simul_err", {63'b0, top_rd_err}, 64'd1);
        chk("simul_fill", {62'b0, fill_cnt}, 64'd1);
        chk("simul_vld", {63'b0, top_rd_vld}, 64'd0);
        read(8'h0D, 1'b0);
        run_stream(1'b0, 5, -1);
        chk("hs_err_run", {32'b0, nhs}, 64'd32);

        // reset mid-stream, then recover
        save(8'h00);
        read(8'h00, 1'b0);
        run_stream(1'b0, -1, 10);
        chk("hs_before_rst", {32'b0, nhs}, 64'd10);
        save(8'h00);
        read(8'h00, 1'b0);
        run_stream(1'b0, -1, -1);
        chk("rst_recover_beat0", {32'b0, got[0]}, 64'h0010_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
